// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_INC   = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetched-instruction buffer: DEPTH entries of {pc, inst}, with flush.
// Push while full is accepted only together with a pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Flush wins over any push or pop in the same cycle.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: it is only observed through a non-zero count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC sequencing, redirect handling and a small fetch buffer.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect targets enter FAULT instead of being aligned.
//
// state    | meaning
// ST_BOOT  | one idle cycle after reset, no fetch
// ST_RUN   | fetching whenever the buffer has room
// ST_FAULT | misaligned redirect seen; fetch halted until aligned redirect
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  target;
  logic         misaligned;
  logic         fetch, flush, pop;
  logic         fifo_full, fifo_empty;
  fetch_entry_t head, push_entry;

  assign imem_addr  = pc_q;
  assign inst_valid = !fifo_empty;
  assign pop        = inst_valid && inst_ready;
  assign inst_data  = fifo_empty ? NOP_INST : head.inst;
  assign inst_pc    = fifo_empty ? 32'h0 : head.pc;
  assign push_entry = '{pc: pc_q, inst: imem_inst};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch      = 1'b0;
    flush      = 1'b0;
    target     = redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    misaligned = |redirect_pc[1:0];
`else
    misaligned = 1'b0;
    target[1:0] = 2'b00;
`endif
    if (redirect_valid) begin
      flush   = 1'b1;
      pc_d    = target;
      state_d = misaligned ? ST_FAULT : ST_RUN;
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN: begin
          if (!fifo_full || pop) begin
            fetch = 1'b1;
            pc_d  = pc_q + PC_INC;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_fault = (state_q == ST_FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fetch),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (flush),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default parameters).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Memory word i holds 32'h1000_0000 + i.
  assign imem_inst = 32'h1000_0000 + (imem_addr >> 2);

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fetch_fault    (fetch_fault)
  );

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = rdy;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    #3;
    tests_run++;
    if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0b exp 0", inst_valid); end
    tests_run++;
    if (fetch_fault !== 1'b0) begin tests_failed++; $display("FAIL reset_fault got %0b exp 0", fetch_fault); end
    tests_run++;
    if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr got %h exp 00000000", imem_addr); end
    tests_run++;
    if (inst_data !== 32'h0000_0013) begin tests_failed++; $display("FAIL reset_data got %h exp 00000013", inst_data); end
    tests_run++;
    if (inst_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got %h exp 00000000", inst_pc); end
  endtask

  task automatic test_startup();
    do_reset(1'b1);
    tests_run++;
    if (imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
      tests_failed++; $display("FAIL start_c0 got addr %h valid %0b exp 00000000 0", imem_addr, inst_valid);
    end
    @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b0 || imem_addr !== 32'h0) begin
      tests_failed++; $display("FAIL start_boot got valid %0b addr %h exp 0 00000000", inst_valid, imem_addr);
    end
    @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b1 || inst_data !== 32'h1000_0000 || inst_pc !== 32'h0 || imem_addr !== 32'h4) begin
      tests_failed++;
      $display("FAIL start_first got v %0b d %h pc %h addr %h exp 1 10000000 00000000 00000004",
               inst_valid, inst_data, inst_pc, imem_addr);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      tests_run++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * k) || inst_data !== 32'h1000_0000 + 32'(k)
          || imem_addr !== 32'(4 * (k + 1))) begin
        tests_failed++;
        $display("FAIL start_seq%0d got v %0b pc %h d %h addr %h exp pc %h", k, inst_valid, inst_pc,
                 inst_data, imem_addr, 32'(4 * k));
      end
    end
  endtask

  task automatic test_stall();
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || imem_addr !== 32'h8) begin
      tests_failed++; $display("FAIL stall_fill got v %0b pc %h addr %h exp 1 00000000 00000008",
                               inst_valid, inst_pc, imem_addr);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (inst_pc !== 32'h0 || inst_data !== 32'h1000_0000 || imem_addr !== 32'h8) begin
      tests_failed++; $display("FAIL stall_hold got pc %h d %h addr %h exp 00000000 10000000 00000008",
                               inst_pc, inst_data, imem_addr);
    end
    inst_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      tests_run++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * k)) begin
        tests_failed++; $display("FAIL stall_drain%0d got v %0b pc %h exp 1 %h", k, inst_valid, inst_pc, 32'(4 * k));
      end
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    tests_run++;
    if (inst_valid !== 1'b0 || imem_addr !== 32'h100) begin
      tests_failed++; $display("FAIL redir_flush got v %0b addr %h exp 0 00000100", inst_valid, imem_addr);
    end
    @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_data !== 32'h1000_0040) begin
      tests_failed++; $display("FAIL redir_first got v %0b pc %h d %h exp 1 00000100 10000040", inst_valid, inst_pc, inst_data);
    end
    @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h104) begin
      tests_failed++; $display("FAIL redir_second got v %0b pc %h exp 1 00000104", inst_valid, inst_pc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
    inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect_valid = 1'b0;
    tests_run++;
    if (inst_valid !== 1'b0 || imem_addr !== 32'hFFFF_FFF8) begin
      tests_failed++; $display("FAIL wrap_flush got v %0b addr %h exp 0 fffffff8", inst_valid, imem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc[k]) begin
        tests_failed++; $display("FAIL wrap_seq%0d got v %0b pc %h exp 1 %h", k, inst_valid, inst_pc, exp_pc[k]);
      end
    end
  endtask

  task automatic test_boot_redirect();
    @(negedge clk);
    rst_n = 1'b0; inst_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040; rst_n = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    tests_run++;
    if (imem_addr !== 32'h40 || inst_valid !== 1'b0) begin
      tests_failed++; $display("FAIL boot_redir got addr %h v %0b exp 00000040 0", imem_addr, inst_valid);
    end
    @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin
      tests_failed++; $display("FAIL boot_redir_fetch got v %0b pc %h exp 1 00000040", inst_valid, inst_pc);
    end
  endtask

  task automatic test_misalign();
    inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    @(negedge clk);
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    tests_run++;
    if (fetch_fault !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== 32'h102) begin
      tests_failed++; $display("FAIL mis_enter got f %0b v %0b addr %h exp 1 0 00000102", fetch_fault, inst_valid, imem_addr);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (fetch_fault !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== 32'h102) begin
      tests_failed++; $display("FAIL mis_hold got f %0b v %0b addr %h exp 1 0 00000102", fetch_fault, inst_valid, imem_addr);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    tests_run++;
    if (fetch_fault !== 1'b0 || imem_addr !== 32'h200) begin
      tests_failed++; $display("FAIL mis_clear got f %0b addr %h exp 0 00000200", fetch_fault, imem_addr);
    end
    @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h200) begin
      tests_failed++; $display("FAIL mis_resume got v %0b pc %h exp 1 00000200", inst_valid, inst_pc);
    end
`else
    tests_run++;
    if (fetch_fault !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 32'h100) begin
      tests_failed++; $display("FAIL mis_align got f %0b v %0b addr %h exp 0 0 00000100", fetch_fault, inst_valid, imem_addr);
    end
    @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || fetch_fault !== 1'b0) begin
      tests_failed++; $display("FAIL mis_fetch got v %0b pc %h f %0b exp 1 00000100 0", inst_valid, inst_pc, fetch_fault);
    end
`endif
  endtask

  task automatic test_async_reset();
    inst_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b1) begin
      tests_failed++; $display("FAIL areset_pre got v %0b exp 1", inst_valid);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (inst_valid !== 1'b0 || imem_addr !== 32'h0 || fetch_fault !== 1'b0 || inst_data !== 32'h0000_0013) begin
      tests_failed++; $display("FAIL areset_now got v %0b addr %h f %0b d %h exp 0 00000000 0 00000013",
                               inst_valid, imem_addr, fetch_fault, inst_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h1000_0000) begin
      tests_failed++; $display("FAIL areset_restart got v %0b pc %h d %h exp 1 00000000 10000000", inst_valid, inst_pc, inst_data);
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_wrap();
    test_boot_redirect();
    test_misalign();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2: fetched-instruction buffer entries; power of two, 2..8.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 imem_addr  output  32  fetch address to the combinational instruction memory.
REQ-006 imem_inst  input  32  instruction word returned in the same cycle for imem_addr.
REQ-007 redirect_valid  input  1  branch/jump/trap redirect request.
REQ-008 redirect_pc  input  32  redirect target.
REQ-009 inst_valid  output  1  head instruction available.
REQ-010 inst_ready  input  1  decode accepts the head instruction.
REQ-011 inst_data  output  32  head instruction word.
REQ-012 inst_pc  output  32  PC of the head instruction.
REQ-013 fetch_fault  output  1  misaligned-target fault flag.

Function
REQ-014 States BOOT, RUN, FAULT; reset enters BOOT; BOOT -> RUN after exactly one clk, with no fetch in BOOT.
REQ-015 imem_addr shall equal the pc register in every state, with no combinational path from inputs.
REQ-016 Fetch in RUN occurs when the buffer is not full, or is full and popped in the same cycle.
- On fetch: push {imem_inst, pc} at the edge; pc <= pc + 4.
REQ-017 pc + 4 shall wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) with no flag.
REQ-018 A pop occurs when inst_valid && inst_ready.
- inst_valid = buffer not empty.
- inst_data and inst_pc come from the head entry.
- Head is stable while inst_valid && !inst_ready.
REQ-019 Latency: an instruction fetched at edge N shall be presented on inst_valid from the cycle after edge N.
REQ-020 When redirect_valid is high, at the edge: buffer flushed, no push, pop ignored, pc <= target.
- Redirect takes priority over all other events in every state, including BOOT.
REQ-021 A redirect in BOOT shall load pc and still transition to RUN.
REQ-022 In FAULT: no fetch, buffer empty, pc held; exit only via an aligned redirect -> RUN.
REQ-023 fetch_fault shall be high exactly while in FAULT.

Reset
REQ-024 Assertion of rst_n shall, immediately and regardless of clk, set:
- state = BOOT, pc = RESET_PC;
- buffer empty, inst_valid = 0, fetch_fault = 0;
- inst_data = 32'h0000_0013, inst_pc = 32'h0.
REQ-025 Reset asserted mid-operation shall discard all buffered instructions; no partial push survives.

Configuration
REQ-026 Macro FETCH_MISALIGN_TRAP_EN defined: a redirect with redirect_pc[1:0] != 0 shall enter FAULT and load pc = redirect_pc unmodified.
REQ-027 Macro FETCH_MISALIGN_TRAP_EN undefined: redirect_pc[1:0] shall be forced to 2'b00.
- FAULT is unreachable.
- fetch_fault is tied to 0.

Structure
REQ-028 Shared package fetch_pkg shall hold:
- the state encoding type (BOOT/RUN/FAULT);
- NOP constant 32'h0000_0013;
- PC increment constant 4.
REQ-029 The buffer shall be a sub-module fetch_fifo (FIFO_DEPTH x 64-bit {pc, inst}) with push, pop, flush, full and empty; simultaneous push and pop when full shall be legal.

Verification
REQ-030 Reset release, inst_ready = 1, memory holds word i = 32'h1000_0000 + i.
- Expect imem_addr 0, 4, 8, ...
- First inst_valid in the 3rd cycle after release, inst_data 32'h1000_0000, inst_pc 0.
REQ-031 inst_ready = 0 for 5 cycles.
- Expect two entries buffered, pc held at 8, head stable.
- Ready = 1: one instruction per cycle with no gap or duplicate.
REQ-032 redirect_pc = 32'h0000_0100 while full and popping.
- Expect inst_valid = 0 next cycle.
- Then inst_pc 32'h100, 32'h104 in order.
REQ-033 Redirect to 32'hFFFF_FFF8, ready = 1.
- Expect inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-034 With the macro, redirect to 32'h0000_0102:
- expect fetch_fault = 1, inst_valid = 0, imem_addr held at 32'h102;
- redirect to 32'h200 clears the fault.
- Without the macro: fetch starts at 32'h100 and fetch_fault stays 0.
REQ-035 Assert rst_n low asynchronously mid-stream with a full buffer.
- Expect inst_valid = 0 and imem_addr = RESET_PC before the next clk edge.
